// File: rtl/cic_pdm_decimator.sv
// Multi-channel CIC decimator: 1-bit PDM streams in, saturated signed PCM out with valid/ready.
// Build option: define CIC_ROUND_EN for round-half-up before the output shift (default floor).

module cic_pdm_decimator #(
  parameter int CHANNELS   = 2,
  parameter int ORDER      = 3,
  parameter int DECIMATION = 64,
  parameter int OUT_W      = 16,
  parameter int ACC_W      = ORDER * $clog2(DECIMATION) + 2,
  parameter int SHIFT      = ACC_W - OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pdm_en,
  input  logic [CHANNELS-1:0]       pdm_in,
  output logic [CHANNELS*OUT_W-1:0] pcm_data,
  output logic                      pcm_valid,
  input  logic                      pcm_ready,
  output logic                      overrun
);

  localparam int CNT_W  = $clog2(DECIMATION);
  localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ACC_ZERO = {ACC_W{1'b0}};
  localparam acc_t ACC_POS1 = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam acc_t ACC_NEG1 = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = WIDE_W'(-(64'sd1 <<< (OUT_W - 1)));
`ifdef CIC_ROUND_EN
  localparam int ROUND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WIDE_W-1:0] ROUND_ADD =
    (SHIFT > 0) ? WIDE_W'(64'sd1 <<< ROUND_POS) : {WIDE_W{1'b0}};
`else
  localparam logic signed [WIDE_W-1:0] ROUND_ADD = {WIDE_W{1'b0}};
`endif

  logic [CNT_W-1:0]          cnt_r;
  logic                      tick_s;
  acc_t                      integ_r     [CHANNELS][ORDER];
  acc_t                      integ_feed_s[CHANNELS][ORDER];
  acc_t                      integ_nxt_s [CHANNELS][ORDER];
  acc_t                      comb_in_r   [CHANNELS];
  acc_t                      comb_x_s    [CHANNELS][ORDER];
  acc_t                      comb_r      [CHANNELS][ORDER];
  acc_t                      dly_r       [CHANNELS][ORDER];
  logic [ORDER:0]            vld_r;
  logic [CHANNELS*OUT_W-1:0] pcm_nxt_s;

  function automatic acc_t map_bit(input logic b);
    map_bit = b ? ACC_POS1 : ACC_NEG1;
  endfunction

  // Widen before rounding so the round constant cannot wrap the comb result.
  function automatic logic [OUT_W-1:0] scale_sat(input acc_t y);
    logic signed [WIDE_W-1:0] w;
    w = WIDE_W'(y) + ROUND_ADD;
    w = w >>> SHIFT;
    if (w > SAT_MAX) begin
      scale_sat = SAT_MAX[OUT_W-1:0];
    end else if (w < SAT_MIN) begin
      scale_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      scale_sat = w[OUT_W-1:0];
    end
  endfunction

  // Tick detection, integrator next-state and comb stage inputs.
  always_comb begin
    tick_s = pdm_en & (cnt_r == CNT_LAST);
    for (int c = 0; c < CHANNELS; c++) begin
      integ_feed_s[c][0] = map_bit(pdm_in[c]);
      comb_x_s[c][0]     = comb_in_r[c];
      for (int k = 1; k < ORDER; k++) begin
        integ_feed_s[c][k] = integ_r[c][k-1];
        comb_x_s[c][k]     = comb_r[c][k-1];
      end
      for (int k = 0; k < ORDER; k++) begin
        integ_nxt_s[c][k] = integ_r[c][k] + integ_feed_s[c][k];
      end
    end
  end

  // Phase counter and integrators advance only on PDM strobes; wrap-around is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          integ_r[c][k] <= ACC_ZERO;
        end
      end
    end else if (pdm_en) begin
      cnt_r <= tick_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < ORDER; k++) begin
          integ_r[c][k] <= integ_nxt_s[c][k];
        end
      end
    end
  end

  // Capture on tick, then one comb stage per clock; delays move only with a valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {(ORDER+1){1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        comb_in_r[c] <= ACC_ZERO;
        for (int k = 0; k < ORDER; k++) begin
          comb_r[c][k] <= ACC_ZERO;
          dly_r[c][k]  <= ACC_ZERO;
        end
      end
    end else begin
      vld_r <= {vld_r[ORDER-1:0], tick_s};
      for (int c = 0; c < CHANNELS; c++) begin
        if (tick_s) begin
          comb_in_r[c] <= integ_nxt_s[c][ORDER-1];
        end
        for (int k = 0; k < ORDER; k++) begin
          if (vld_r[k]) begin
            comb_r[c][k] <= comb_x_s[c][k] - dly_r[c][k];
            dly_r[c][k]  <= comb_x_s[c][k];
          end
        end
      end
    end
  end

  // Scale and saturate the last comb stage of every channel.
  always_comb begin
    pcm_nxt_s = {(CHANNELS*OUT_W){1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      pcm_nxt_s[c*OUT_W +: OUT_W] = scale_sat(comb_r[c][ORDER-1]);
    end
  end

  // Output register with valid/ready handshake; a sample arriving into a full slot is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcm_data  <= {(CHANNELS*OUT_W){1'b0}};
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (vld_r[ORDER]) begin
      if (!pcm_valid || pcm_ready) begin
        pcm_data  <= pcm_nxt_s;
        pcm_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// Self-checking bench for cic_pdm_decimator: default build plus a SHIFT=2 instance sharing stimulus.
// Reference model uses exact cumulative sums and binomial differences on 64-bit integers.

module tb_cic_pdm_decimator;

  localparam int CH  = 2;
  localparam int N   = 3;
  localparam int R   = 64;
  localparam int OW  = 16;
  localparam int AW  = N * $clog2(R) + 2;
  localparam int SH  = AW - OW;
  localparam int SH2 = 2;

  logic clk = 1'b0;
  logic rst, pdm_en, pcm_ready;
  logic [CH-1:0] pdm_in;
  logic [CH*OW-1:0] pcm_data, pcm_data2;
  logic pcm_valid, pcm_valid2, overrun, overrun2;

  always #5 clk = ~clk;

  cic_pdm_decimator #(.CHANNELS(CH), .ORDER(N), .DECIMATION(R), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .pdm_en(pdm_en), .pdm_in(pdm_in), .pcm_data(pcm_data),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overrun(overrun));

  cic_pdm_decimator #(.CHANNELS(CH), .ORDER(N), .DECIMATION(R), .OUT_W(OW), .SHIFT(SH2)) dut_s2 (
    .clk(clk), .rst(rst), .pdm_en(pdm_en), .pdm_in(pdm_in), .pcm_data(pcm_data2),
    .pcm_valid(pcm_valid2), .pcm_ready(pcm_ready), .overrun(overrun2));

  // reference model state
  longint cs [CH][N+1];
  longint hist [CH][$];
  longint sq [CH][$];
  int     pend_due[$];
  longint pend_raw[$];
  int     nsamp, edge_cnt;
  logic   m_valid, m_overrun;
  logic [CH*OW-1:0] m_data, m_data2;
  int     n_checks, n_fail;

  function automatic logic [OW-1:0] exp_scale(input longint raw, input int sh);
    longint w, lim;
    w = raw & ((64'sd1 <<< AW) - 64'sd1);
    if (w >= (64'sd1 <<< (AW - 1))) w = w - (64'sd1 <<< AW);
`ifdef CIC_ROUND_EN
    if (sh > 0) w = w + (64'sd1 <<< (sh - 1));
`endif
    w = w >>> sh;
    lim = 64'sd1 <<< (OW - 1);
    if (w > lim - 1) w = lim - 1;
    else if (w < -lim) w = -lim;
    return w[OW-1:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      for (int j = 0; j <= N; j++) cs[c][j] = 0;
      hist[c].delete();
      sq[c].delete();
    end
    pend_due.delete();
    pend_raw.delete();
    nsamp = 0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_data = '0;
    m_data2 = '0;
  endtask

  // Predict the effect of the coming rising edge from the inputs now applied.
  task automatic model_edge();
    longint x, raw, coef, s;
    int m, idx;
    logic [CH*OW-1:0] nd, nd2;
    edge_cnt++;
    if (rst) begin
      model_clear();
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == edge_cnt) begin
        void'(pend_due.pop_front());
        nd = '0;
        nd2 = '0;
        for (int c = 0; c < CH; c++) begin
          raw = pend_raw.pop_front();
          nd[c*OW +: OW]  = exp_scale(raw, SH);
          nd2[c*OW +: OW] = exp_scale(raw, SH2);
        end
        if (!m_valid || pcm_ready) begin
          m_valid = 1'b1;
          m_data = nd;
          m_data2 = nd2;
        end else begin
          m_overrun = 1'b1;
        end
      end else if (pcm_ready) begin
        m_valid = 1'b0;
      end
      if (pdm_en) begin
        nsamp++;
        for (int c = 0; c < CH; c++) begin
          x = pdm_in[c] ? 64'sd1 : -64'sd1;
          cs[c][1] += x;
          for (int j = 2; j <= N; j++) cs[c][j] += cs[c][j-1];
          hist[c].push_back(cs[c][N]);
        end
        if (nsamp % R == 0) begin
          for (int c = 0; c < CH; c++) begin
            // each registered integrator hop delays the N-fold running sum by one sample
            idx = nsamp - 1 - (N - 1);
            s = (idx >= 0) ? hist[c][idx] : 64'sd0;
            sq[c].push_back(s);
            m = sq[c].size() - 1;
            raw = 0;
            coef = 1;
            for (int j = 0; j <= N; j++) begin
              if (m - j >= 0) raw += ((j % 2) ? -coef : coef) * sq[c][m-j];
              coef = coef * (N - j) / (j + 1);
            end
            pend_raw.push_back(raw);
          end
          pend_due.push_back(edge_cnt + N + 1);
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic [CH-1:0] din, input logic rdy, input logic r);
    rst = r;
    pdm_en = en;
    pdm_in = din;
    pcm_ready = rdy;
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CH'($urandom), 1'($urandom), 1'b1);
      n_checks++;
      if ({pcm_valid, overrun, pcm_data, pcm_valid2, overrun2, pcm_data2} !== '0) begin
        n_fail++;
        $display("FAIL reset: got v=%b o=%b d=%h / v=%b o=%b d=%h, want all zero",
                 pcm_valid, overrun, pcm_data, pcm_valid2, overrun2, pcm_data2);
      end
    end
  endtask

  task automatic test_ones_zeros();
    int nv, last;
    nv = 0;
    last = -1;
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < R * 6 + 8; i++) begin
      step(1'b1, 2'b01, 1'b1, 1'b0);
      n_checks++;
      if ({pcm_valid, overrun, pcm_valid2, overrun2} !== {m_valid, m_overrun, m_valid, m_overrun}) begin
        n_fail++;
        $display("FAIL ones_flags edge %0d: got %b%b%b%b want %b%b", edge_cnt,
                 pcm_valid, overrun, pcm_valid2, overrun2, m_valid, m_overrun);
      end
      if (m_valid) begin
        n_checks++;
        if ({pcm_data, pcm_data2} !== {m_data, m_data2}) begin
          n_fail++;
          $display("FAIL ones_data edge %0d: got %h/%h want %h/%h", edge_cnt, pcm_data, pcm_data2, m_data, m_data2);
        end
      end
      if (pcm_valid) begin
        nv++;
        if (nv >= N + 1) begin
          n_checks++;
          if ({pcm_data, pcm_data2} !== {32'hC000_4000, 32'h8000_7FFF}) begin
            n_fail++;
            $display("FAIL ones_settled: got %h/%h want c0004000/80007fff", pcm_data, pcm_data2);
          end
        end
        if (last >= 0) begin
          n_checks++;
          if (edge_cnt - last != R) begin
            n_fail++;
            $display("FAIL ones_period: got %0d want %0d", edge_cnt - last, R);
          end
        end
        last = edge_cnt;
      end
    end
    n_checks++;
    if (nv != 6) begin
      n_fail++;
      $display("FAIL ones_count: got %0d valids want 6", nv);
    end
  endtask

  task automatic test_alternating();
    int nv;
    logic b;
    nv = 0;
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < R * 6 + 8; i++) begin
      b = (i % 2 == 0);
      step(1'b1, {b, b}, 1'b1, 1'b0);
      n_checks++;
      if ({pcm_valid, overrun, pcm_valid2, overrun2} !== {m_valid, m_overrun, m_valid, m_overrun}) begin
        n_fail++;
        $display("FAIL alt_flags edge %0d: got %b%b%b%b want %b%b", edge_cnt,
                 pcm_valid, overrun, pcm_valid2, overrun2, m_valid, m_overrun);
      end
      if (m_valid) begin
        n_checks++;
        if ({pcm_data, pcm_data2} !== {m_data, m_data2}) begin
          n_fail++;
          $display("FAIL alt_data edge %0d: got %h/%h want %h/%h", edge_cnt, pcm_data, pcm_data2, m_data, m_data2);
        end
      end
      if (pcm_valid) begin
        nv++;
        if (nv >= N + 1) begin
          n_checks++;
          if ({pcm_data, pcm_data2} !== 64'h0) begin
            n_fail++;
            $display("FAIL alt_settled: got %h/%h want 0", pcm_data, pcm_data2);
          end
        end
      end
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_sparse_en();
    int k, nv, tick_edge, last;
    logic en, prev_v;
    k = 0; nv = 0; tick_edge = -1000; last = -1; prev_v = 1'b0;
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 4 * R * 5 + 20; i++) begin
      en = (i % 4 == 0);
      step(en, 2'b11, 1'b1, 1'b0);
      if (en) begin
        k++;
        if (k % R == 0) tick_edge = edge_cnt;
      end
      n_checks++;
      if ({pcm_valid, overrun} !== {m_valid, m_overrun} || (m_valid && pcm_data !== m_data)) begin
        n_fail++;
        $display("FAIL sparse_model edge %0d: got %b%b %h want %b%b %h", edge_cnt,
                 pcm_valid, overrun, pcm_data, m_valid, m_overrun, m_data);
      end
      if (pcm_valid && !prev_v) begin
        nv++;
        n_checks++;
        if (edge_cnt - tick_edge != N + 1) begin
          n_fail++;
          $display("FAIL sparse_latency: got %0d want %0d", edge_cnt - tick_edge, N + 1);
        end
        if (last >= 0) begin
          n_checks++;
          if (edge_cnt - last != 4 * R) begin
            n_fail++;
            $display("FAIL sparse_period: got %0d want %0d", edge_cnt - last, 4 * R);
          end
        end
        last = edge_cnt;
        if (nv >= N + 1) begin
          n_checks++;
          if (pcm_data !== 32'h4000_4000) begin
            n_fail++;
            $display("FAIL sparse_settled: got %h want 40004000", pcm_data);
          end
        end
      end
      prev_v = pcm_valid;
    end
    n_checks++;
    if (nv != 5) begin
      n_fail++;
      $display("FAIL sparse_count: got %0d want 5", nv);
    end
  endtask

  task automatic test_overrun();
    logic got_first;
    logic [CH*OW-1:0] first;
    got_first = 1'b0;
    first = '0;
    step(1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 2 * R + 10; i++) begin
      step(1'b1, 2'b11, 1'b0, 1'b0);
      n_checks++;
      if ({pcm_valid, overrun} !== {m_valid, m_overrun} || (m_valid && pcm_data !== m_data)) begin
        n_fail++;
        $display("FAIL ovr_hold edge %0d: got %b%b %h want %b%b %h", edge_cnt,
                 pcm_valid, overrun, pcm_data, m_valid, m_overrun, m_data);
      end
      if (m_valid && !got_first) begin
        first = m_data;
        got_first = 1'b1;
      end
    end
    n_checks++;
    if ({pcm_valid, overrun, pcm_data} !== {1'b1, 1'b1, first}) begin
      n_fail++;
      $display("FAIL ovr_state: got v=%b o=%b d=%h want v=1 o=1 d=%h", pcm_valid, overrun, pcm_data, first);
    end
    step(1'b1, 2'b11, 1'b1, 1'b0);
    n_checks++;
    if ({pcm_valid, overrun} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovr_accept: got v=%b o=%b want v=0 o=1", pcm_valid, overrun);
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 2'b11, 1'b1, 1'b0);
      n_checks++;
      if ({pcm_valid, overrun} !== {m_valid, m_overrun} || (m_valid && pcm_data !== m_data)) begin
        n_fail++;
        $display("FAIL ovr_after edge %0d: got %b%b %h want %b%b %h", edge_cnt,
                 pcm_valid, overrun, pcm_data, m_valid, m_overrun, m_data);
      end
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 2'b00, 1'b0, 1'b1);
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, CH'($urandom), (k >= 2 * R + N + 1), 1'b0);
      n_checks++;
      if ({pcm_valid, overrun} !== {m_valid, m_overrun} || (m_valid && pcm_data !== m_data)) begin
        n_fail++;
        $display("FAIL b2b_model edge %0d: got %b%b %h want %b%b %h", edge_cnt,
                 pcm_valid, overrun, pcm_data, m_valid, m_overrun, m_data);
      end
      if (k == 2 * R + N + 1) begin
        n_checks++;
        if (pcm_valid !== 1'b1 || overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_replace: got v=%b o=%b want v=1 o=0", pcm_valid, overrun);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int k = 1; k <= R + 2; k++) step(1'b1, CH'($urandom), 1'b1, 1'b0);
    step(1'b1, CH'($urandom), 1'b1, 1'b1);
    n_checks++;
    if ({pcm_valid, overrun, pcm_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b o=%b d=%h want zeros", pcm_valid, overrun, pcm_data);
    end
    for (int k = 1; k <= R + 6; k++) begin
      step(1'b1, CH'($urandom), 1'b1, 1'b0);
      n_checks++;
      if (pcm_valid !== (k == R + N + 1)) begin
        n_fail++;
        $display("FAIL mid_valid k=%0d: got %b want %b", k, pcm_valid, (k == R + N + 1));
      end
      n_checks++;
      if ({pcm_valid, overrun} !== {m_valid, m_overrun} || (m_valid && pcm_data !== m_data)) begin
        n_fail++;
        $display("FAIL mid_model edge %0d: got %b%b %h want %b%b %h", edge_cnt,
                 pcm_valid, overrun, pcm_data, m_valid, m_overrun, m_data);
      end
    end
  endtask

  task automatic test_random();
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, CH'($urandom), ($urandom % 8) == 0, ($urandom % 1500) == 0);
      n_checks++;
      if ({pcm_valid, overrun, pcm_valid2, overrun2} !== {m_valid, m_overrun, m_valid, m_overrun}) begin
        n_fail++;
        $display("FAIL rand_flags edge %0d: got %b%b%b%b want %b%b", edge_cnt,
                 pcm_valid, overrun, pcm_valid2, overrun2, m_valid, m_overrun);
      end
      if (m_valid) begin
        n_checks++;
        if ({pcm_data, pcm_data2} !== {m_data, m_data2}) begin
          n_fail++;
          $display("FAIL rand_data edge %0d: got %h/%h want %h/%h", edge_cnt, pcm_data, pcm_data2, m_data, m_data2);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    edge_cnt = 0;
    rst = 1'b1;
    pdm_en = 1'b0;
    pdm_in = '0;
    pcm_ready = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_ones_zeros();
    test_alternating();
    test_sparse_en();
    test_overrun();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
